// File: rtl/bg_scroll_pkg.sv
// Shared geometry, types and camera-step helpers for the Green Hill background scroller.
package bg_scroll_pkg;

    localparam int MAP_W    = 1968;
    localparam int MAP_H    = 128;
    localparam int X_SCALE  = 7;
    localparam int Y_SCALE  = 9;
    localparam int VIEW_W   = 92;
    localparam int VIEW_H   = 54;
    localparam int DEAD_L   = 32;
    localparam int DEAD_R   = 56;
    localparam int DEAD_T   = 16;
    localparam int DEAD_B   = 40;
    localparam int MAX_STEP = 8;
    localparam int Y_INIT   = 54;
    localparam int ACT_W    = 640;
    localparam int ACT_H    = 480;

    typedef logic [10:0]        cam_x_t;
    typedef logic [6:0]         cam_y_t;
    typedef logic signed [12:0] cam_calc_t;

    typedef enum logic [2:0] {
        CAM_IDLE   = 3'd0,
        CAM_LATCH  = 3'd1,
        CAM_STEP_X = 3'd2,
        CAM_STEP_Y = 3'd3,
        CAM_CLAMP  = 3'd4,
        CAM_COMMIT = 3'd5
    } cam_state_e;

    localparam cam_calc_t DEAD_L_C   = cam_calc_t'(DEAD_L);
    localparam cam_calc_t DEAD_R_C   = cam_calc_t'(DEAD_R);
    localparam cam_calc_t DEAD_T_C   = cam_calc_t'(DEAD_T);
    localparam cam_calc_t DEAD_B_C   = cam_calc_t'(DEAD_B);
    localparam cam_calc_t MAX_STEP_C = cam_calc_t'(MAX_STEP);
    localparam cam_calc_t X_MAX_C    = cam_calc_t'(MAP_W - VIEW_W);
    localparam cam_calc_t Y_MAX_C    = cam_calc_t'(MAP_H - VIEW_H);

    // Move the camera toward the target only when it leaves the deadzone, rate-limited.
    function automatic cam_calc_t step_toward(input cam_calc_t cam, input cam_calc_t tgt,
                                              input cam_calc_t lo_off, input cam_calc_t hi_off);
        cam_calc_t lo;
        cam_calc_t hi;
        cam_calc_t d;
        cam_calc_t step;
        lo = cam + lo_off;
        hi = cam + hi_off;
        if (tgt < lo) d = tgt - lo;
        else if (tgt > hi) d = tgt - hi;
        else d = 13'sd0;
        if (d > MAX_STEP_C) step = MAX_STEP_C;
        else if (d < -MAX_STEP_C) step = -MAX_STEP_C;
        else step = d;
        return cam + step;
    endfunction

    function automatic cam_calc_t clamp_to(input cam_calc_t v, input cam_calc_t hi);
        cam_calc_t r;
        if (v < 13'sd0) r = 13'sd0;
        else if (v > hi) r = hi;
        else r = v;
        return r;
    endfunction

endpackage

// File: rtl/bg_scroll_ctrl_if.sv
// Pixel-timing, Sonic position and camera/address result bundle around bg_scroll_ctrl.
interface bg_scroll_ctrl_if;
    import bg_scroll_pkg::*;

    logic        frame_start;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    cam_x_t      sonic_x;
    cam_y_t      sonic_y;
    logic [17:0] rom_address;
    cam_x_t      cam_x;
    cam_y_t      cam_y;
    logic        cam_update;
    logic        overrun;

    modport master (output frame_start, DrawX, DrawY, sonic_x, sonic_y,
                    input  rom_address, cam_x, cam_y, cam_update, overrun);
    modport slave  (input  frame_start, DrawX, DrawY, sonic_x, sonic_y,
                    output rom_address, cam_x, cam_y, cam_update, overrun);
endinterface

// File: rtl/bg_addr_gen.sv
// Per-pixel background ROM address sequencer built from scale counters and a running row base.
module bg_addr_gen
    import bg_scroll_pkg::*;
(
    input  logic        vga_clk,
    input  logic        reset_n,
    input  cam_x_t      cam_x,
    input  cam_y_t      cam_y,
    input  logic [17:0] cam_base,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    output logic [17:0] rom_address
);
    localparam logic [2:0]  COL_SUB_LAST = 3'(X_SCALE - 1);
    localparam logic [3:0]  ROW_SUB_LAST = 4'(Y_SCALE - 1);
    localparam logic [17:0] ROW_STEP     = 18'(MAP_W);
    localparam logic [17:0] INIT_BASE    = 18'(Y_INIT * MAP_W);

    cam_x_t      frame_cam_x_r;
    cam_x_t      col_r;
    cam_x_t      col_nxt_s;
    cam_x_t      line_cam_x_s;
    logic [2:0]  col_sub_r;
    logic [2:0]  col_sub_nxt_s;
    cam_y_t      row_r;
    cam_y_t      row_nxt_s;
    logic [3:0]  row_sub_r;
    logic [3:0]  row_sub_nxt_s;
    logic [17:0] row_base_r;
    logic [17:0] row_base_nxt_s;
    logic [17:0] rom_address_r;
    logic        frame_top_s;
    logic        pix_active_s;

    assign frame_top_s  = (draw_x == 10'd0) && (draw_y == 10'd0);
    assign pix_active_s = (draw_x < 10'(ACT_W)) && (draw_y < 10'(ACT_H));
    // The frame's first pixel takes the committed camera; later lines reuse that frame's copy.
    assign line_cam_x_s = frame_top_s ? cam_x : frame_cam_x_r;

    // Counter values that belong to the pixel currently presented on draw_x/draw_y.
    always_comb begin
        col_sub_nxt_s  = col_sub_r;
        col_nxt_s      = col_r;
        row_sub_nxt_s  = row_sub_r;
        row_nxt_s      = row_r;
        row_base_nxt_s = row_base_r;
        if (draw_x == 10'd0) begin
            col_sub_nxt_s = 3'd0;
            col_nxt_s     = line_cam_x_s;
            if (draw_y == 10'd0) begin
                row_sub_nxt_s  = 4'd0;
                row_nxt_s      = cam_y;
                row_base_nxt_s = cam_base;
            end else if (row_sub_r == ROW_SUB_LAST) begin
                row_sub_nxt_s  = 4'd0;
                row_nxt_s      = row_r + 7'd1;
                row_base_nxt_s = row_base_r + ROW_STEP;
            end else begin
                row_sub_nxt_s = row_sub_r + 4'd1;
            end
        end else if (col_sub_r == COL_SUB_LAST) begin
            col_sub_nxt_s = 3'd0;
            col_nxt_s     = col_r + 11'd1;
        end else begin
            col_sub_nxt_s = col_sub_r + 3'd1;
        end
    end

    // Counters advance and the address registers only inside the active area; it holds elsewhere.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cam_x_r <= 11'd0;
            col_r         <= 11'd0;
            col_sub_r     <= 3'd0;
            row_r         <= cam_y_t'(Y_INIT);
            row_sub_r     <= 4'd0;
            row_base_r    <= INIT_BASE;
            rom_address_r <= INIT_BASE;
        end else if (pix_active_s) begin
            if (frame_top_s) frame_cam_x_r <= cam_x;
            col_r         <= col_nxt_s;
            col_sub_r     <= col_sub_nxt_s;
            row_r         <= row_nxt_s;
            row_sub_r     <= row_sub_nxt_s;
            row_base_r    <= row_base_nxt_s;
            rom_address_r <= row_base_nxt_s + 18'(col_nxt_s);
        end
    end

    assign rom_address = rom_address_r;

endmodule

// File: rtl/bg_scroll_ctrl.sv
// Green Hill camera controller: a once-per-frame deadzone/rate-limited/clamped camera FSM
// driving the per-pixel background ROM address sequencer.
module bg_scroll_ctrl
    import bg_scroll_pkg::*;
(
    input  logic            vga_clk,
    input  logic            reset_n,
    bg_scroll_ctrl_if.slave bus
);
    localparam logic [2:0] ST_IDLE   = 3'(CAM_IDLE);
    localparam logic [2:0] ST_LATCH  = 3'(CAM_LATCH);
    localparam logic [2:0] ST_STEP_X = 3'(CAM_STEP_X);
    localparam logic [2:0] ST_STEP_Y = 3'(CAM_STEP_Y);
    localparam logic [2:0] ST_CLAMP  = 3'(CAM_CLAMP);
    localparam logic [2:0] ST_COMMIT = 3'(CAM_COMMIT);

    logic [2:0]  state_r;
    cam_calc_t   wx_r;
    cam_calc_t   wy_r;
    cam_calc_t   nx_r;
    cam_calc_t   ny_r;
    cam_calc_t   cx_s;
    cam_calc_t   cy_s;
    cam_x_t      cam_x_r;
    cam_y_t      cam_y_r;
    logic [17:0] cam_base_r;
    logic        cam_update_r;
    logic        overrun_r;
    logic [17:0] rom_address_s;

    assign cx_s = $signed({2'b00, cam_x_r});
    assign cy_s = $signed({6'b000000, cam_y_r});

    // Camera FSM; the committed registers double as the shadow copy the address path samples.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            wx_r         <= 13'sd0;
            wy_r         <= 13'sd0;
            nx_r         <= 13'sd0;
            ny_r         <= 13'sd0;
            cam_x_r      <= 11'd0;
            cam_y_r      <= cam_y_t'(Y_INIT);
            cam_base_r   <= 18'(Y_INIT * MAP_W);
            cam_update_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            cam_update_r <= 1'b0;
            if (bus.frame_start && (state_r != ST_IDLE)) overrun_r <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (bus.frame_start) state_r <= ST_LATCH;
                end
                ST_LATCH: begin
                    wx_r    <= $signed({2'b00, bus.sonic_x});
                    wy_r    <= $signed({6'b000000, bus.sonic_y});
                    state_r <= ST_STEP_X;
                end
                ST_STEP_X: begin
                    nx_r    <= step_toward(cx_s, wx_r, DEAD_L_C, DEAD_R_C);
                    state_r <= ST_STEP_Y;
                end
                ST_STEP_Y: begin
                    ny_r    <= step_toward(cy_s, wy_r, DEAD_T_C, DEAD_B_C);
                    state_r <= ST_CLAMP;
                end
                ST_CLAMP: begin
                    nx_r    <= clamp_to(nx_r, X_MAX_C);
                    ny_r    <= clamp_to(ny_r, Y_MAX_C);
                    state_r <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    cam_x_r      <= cam_x_t'(nx_r);
                    cam_y_r      <= cam_y_t'(ny_r);
                    cam_base_r   <= 18'(cam_y_t'(ny_r)) * 18'(MAP_W);
                    cam_update_r <= 1'b1;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    bg_addr_gen u_addr_gen (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .cam_x       (cam_x_r),
        .cam_y       (cam_y_r),
        .cam_base    (cam_base_r),
        .draw_x      (bus.DrawX),
        .draw_y      (bus.DrawY),
        .rom_address (rom_address_s)
    );

    assign bus.rom_address = rom_address_s;
    assign bus.cam_x       = cam_x_r;
    assign bus.cam_y       = cam_y_r;
    assign bus.cam_update  = cam_update_r;
    assign bus.overrun     = overrun_r;

endmodule

// File: tb/tb_bg_scroll_ctrl.sv
// Self-checking bench for bg_scroll_ctrl: camera vector table plus address-scan scoreboard.
module tb_bg_scroll_ctrl;
    import bg_scroll_pkg::*;

    typedef struct {
        logic [10:0] sx;
        logic [6:0]  sy;
        logic [10:0] ex;
        logic [6:0]  ey;
    } cam_vec_t;

    logic        vga_clk;
    logic        reset_n;
    int          checks;
    int          errors;
    int          addr_q[$];
    logic [17:0] cam_q[$];
    cam_vec_t    tbl[12];
    int          mcx;
    int          mcy;
    int          pulses;
    int          ex;
    int          ey;

    bg_scroll_ctrl_if bus();

    bg_scroll_ctrl dut (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_step(input int cam, input int s, input int lo, input int hi,
                                      input int maxv);
        int d;
        int n;
        d = 0;
        if (s < cam + lo) d = s - (cam + lo);
        else if (s > cam + hi) d = s - (cam + hi);
        if (d > 8) d = 8;
        if (d < -8) d = -8;
        n = cam + d;
        if (n < 0) n = 0;
        if (n > maxv) n = maxv;
        return n;
    endfunction

    // One camera update: expected result queued at the pulse, compared when cam_update fires.
    task automatic run_frame(input string tag, input logic [10:0] sx, input logic [6:0] sy,
                             input logic [10:0] ex_i, input logic [6:0] ey_i);
        logic [10:0] qx;
        logic [6:0]  qy;
        int          waited;
        bus.sonic_x     = sx;
        bus.sonic_y     = sy;
        bus.frame_start = 1'b1;
        cam_q.push_back({ex_i, ey_i});
        tick();
        bus.frame_start = 1'b0;
        waited = 0;
        while (bus.cam_update !== 1'b1 && waited < 12) begin
            tick();
            waited++;
        end
        {qx, qy} = cam_q.pop_front();
        check({tag, "_update"}, int'(bus.cam_update), 1);
        if (bus.cam_update === 1'b1) begin
            check({tag, "_cam_x"}, int'(bus.cam_x), int'(qx));
            check({tag, "_cam_y"}, int'(bus.cam_y), int'(qy));
            tick();
            check({tag, "_update_drop"}, int'(bus.cam_update), 0);
        end
    endtask

    // Scan nlines full lines from the top of a frame; address model uses division.
    task automatic scan_frame(input int cx, input int cy, input int nlines);
        int exp_last;
        exp_last = 0;
        for (int y = 0; y < nlines; y++) begin
            for (int x = 0; x < 800; x++) begin
                tick();
                if (addr_q.size() > 0) check("addr", int'(bus.rom_address), addr_q.pop_front());
                bus.DrawX = 10'(x);
                bus.DrawY = 10'(y);
                if (x < 640 && y < 480) exp_last = (cy + y / 9) * 1968 + cx + x / 7;
                addr_q.push_back(exp_last);
            end
        end
        tick();
        if (addr_q.size() > 0) check("addr", int'(bus.rom_address), addr_q.pop_front());
        bus.DrawX = 10'd700;
        bus.DrawY = 10'd500;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tbl[0]  = '{11'd200, 7'd80,  11'd8,  7'd54};
        tbl[1]  = '{11'd200, 7'd80,  11'd16, 7'd54};
        tbl[2]  = '{11'd200, 7'd80,  11'd24, 7'd54};
        tbl[3]  = '{11'd50,  7'd80,  11'd18, 7'd54};
        tbl[4]  = '{11'd60,  7'd80,  11'd18, 7'd54};
        tbl[5]  = '{11'd60,  7'd100, 11'd18, 7'd60};
        tbl[6]  = '{11'd60,  7'd127, 11'd18, 7'd68};
        tbl[7]  = '{11'd60,  7'd127, 11'd18, 7'd74};
        tbl[8]  = '{11'd60,  7'd0,   11'd18, 7'd66};
        tbl[9]  = '{11'd0,   7'd60,  11'd10, 7'd58};
        tbl[10] = '{11'd0,   7'd60,  11'd2,  7'd50};
        tbl[11] = '{11'd0,   7'd60,  11'd0,  7'd44};

        reset_n         = 1'b0;
        bus.frame_start = 1'b0;
        bus.sonic_x     = 11'd0;
        bus.sonic_y     = 7'd0;
        bus.DrawX       = 10'd300;
        bus.DrawY       = 10'd100;
        tick();
        tick();
        check("rst_cam_x", int'(bus.cam_x), 0);
        check("rst_cam_y", int'(bus.cam_y), 54);
        check("rst_rom_address", int'(bus.rom_address), 106272);
        check("rst_cam_update", int'(bus.cam_update), 0);
        check("rst_overrun", int'(bus.overrun), 0);
        reset_n = 1'b1;
        tick();
        check("rst_release_rom", int'(bus.rom_address), 106272);
        bus.DrawX = 10'd700;
        bus.DrawY = 10'd500;
        tick();

        mcx = 0;
        mcy = 54;
        scan_frame(mcx, mcy, 12);

        for (int i = 0; i < 9; i++) begin
            run_frame($sformatf("vec%0d", i), tbl[i].sx, tbl[i].sy, tbl[i].ex, tbl[i].ey);
            mcx = int'(tbl[i].ex);
            mcy = int'(tbl[i].ey);
        end

        // A commit landing mid-scan must not disturb the frame in flight.
        fork
            scan_frame(mcx, mcy, 12);
            begin
                repeat (3 * 800) tick();
                run_frame("vec9_mid", tbl[9].sx, tbl[9].sy, tbl[9].ex, tbl[9].ey);
            end
        join
        mcx = int'(tbl[9].ex);
        mcy = int'(tbl[9].ey);
        scan_frame(mcx, mcy, 12);

        for (int i = 10; i < 12; i++) begin
            run_frame($sformatf("vec%0d", i), tbl[i].sx, tbl[i].sy, tbl[i].ex, tbl[i].ey);
            mcx = int'(tbl[i].ex);
            mcy = int'(tbl[i].ey);
        end

        for (int i = 0; i < 20; i++) begin
            ex = model_step(mcx, 200, 32, 56, 1876);
            run_frame("chase200", 11'd200, 7'd60, 11'(ex), 7'(mcy));
            mcx = ex;
        end
        check("chase200_final", int'(bus.cam_x), 144);

        for (int i = 0; i < 225; i++) begin
            ex = model_step(mcx, 1960, 32, 56, 1876);
            run_frame("chase1960", 11'd1960, 7'd60, 11'(ex), 7'(mcy));
            mcx = ex;
        end
        check("clamp_right", int'(bus.cam_x), 1876);

        for (int i = 0; i < 240; i++) begin
            ex = model_step(mcx, 0, 32, 56, 1876);
            run_frame("chase0", 11'd0, 7'd60, 11'(ex), 7'(mcy));
            mcx = ex;
        end
        check("clamp_left", int'(bus.cam_x), 0);

        check("overrun_clear", int'(bus.overrun), 0);
        bus.sonic_x = 11'd200;
        bus.sonic_y = 7'd60;
        ex = model_step(mcx, 200, 32, 56, 1876);
        ey = model_step(mcy, 60, 16, 40, 74);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        tick();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.cam_update === 1'b1) begin
                pulses++;
                check("overrun_cam_x", int'(bus.cam_x), ex);
                check("overrun_cam_y", int'(bus.cam_y), ey);
            end
        end
        check("overrun_pulses", pulses, 1);
        check("overrun_set", int'(bus.overrun), 1);
        mcx = ex;
        mcy = ey;
        ex = model_step(mcx, 200, 32, 56, 1876);
        run_frame("after_overrun", 11'd200, 7'd60, 11'(ex), 7'(mcy));
        check("overrun_sticky", int'(bus.overrun), 1);

        bus.DrawX = 10'd300;
        bus.DrawY = 10'd100;
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        check("rst2_cam_x", int'(bus.cam_x), 0);
        check("rst2_cam_y", int'(bus.cam_y), 54);
        check("rst2_rom_address", int'(bus.rom_address), 106272);
        check("rst2_overrun", int'(bus.overrun), 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("rst2_release_rom", int'(bus.rom_address), 106272);
        check("rst2_release_overrun", int'(bus.overrun), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
